refill_responder: RTL and testbench
===================================

REFILL_RESPONDER -- requirements
Module: refill_responder

Interface
REQ-001 SHALL have parameters: PADDR_WIDTH, default 56, physical address width; LINE_SIZE, default 64, line bytes; TIMEOUT_CYCLES, default 256, response watchdog limit.
REQ-002 SHALL have ports (dir, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- line_req, in, 1, one-cycle line refill request pulse from the L1 refill port.
- line_addr, in, PADDR_WIDTH, line refill address.
- line_ack, out, 1, one-cycle pulse: line_data holds the complete line.
- line_data, out, LINE_SIZE*8, assembled line.
- line_error, out, 1, one-cycle pulse: refill failed.
- busy, out, 1, refill in progress.
- bus_req_valid, out, 1, beat read request.
- bus_req_ready, in, 1, downstream accepts the beat request.
- bus_req_addr, out, PADDR_WIDTH, beat address.
- bus_resp_valid, in, 1, beat response.
- bus_resp_data, in, 64, beat data.
- bus_resp_error, in, 1, beat error, qualified by bus_resp_valid.

Function
REQ-003 SHALL use FSM states IDLE, FILL, DONE, FAIL.
REQ-004 IDLE: line_req=1 SHALL latch line_addr with bits [5:0] forced to 0, clear beat counters and the sticky error flag, and go to FILL.
REQ-005 line_req outside IDLE SHALL be ignored; busy SHALL be 1 in every state except IDLE.
REQ-006 FILL: bus_req_valid SHALL be 1 while issued count < 8; bus_req_addr SHALL be {latched_addr[PADDR_WIDTH-1:6], issue_idx[2:0], 3'b000}.
REQ-007 An issue SHALL occur when bus_req_valid && bus_req_ready; issue_idx then increments. Up to 8 beats may be outstanding.
REQ-008 Responses SHALL be in order; the k-th bus_resp_valid SHALL write bus_resp_data into line_data[64k+63:64k], k=0..7.
REQ-009 Any response with bus_resp_error=1 SHALL set the sticky error flag; its data SHALL still be written.
REQ-010 Issue and response in the same cycle SHALL both be processed.
REQ-011 When the 8th response is captured, the next state SHALL be DONE if the error flag (including the 8th beat's error) is clear, otherwise FAIL.
REQ-012 DONE SHALL assert line_ack=1 for exactly one cycle, then go to IDLE; FAIL SHALL assert line_error=1 for exactly one cycle, then go to IDLE.
REQ-013 line_ack and line_error SHALL never both be 1.
REQ-014 line_data SHALL hold its value from the ack cycle until the next accepted line_req.
REQ-015 bus_resp_valid in IDLE, DONE or FAIL SHALL be ignored.
REQ-016 Latency with bus_req_ready=1 and 1-cycle response: line_req at cycle 0; beats issue at cycles 1-8; responses arrive at cycles 2-9; line_ack at cycle 10.

Reset
REQ-017 While rst_n=0, asynchronously, the FSM SHALL be IDLE and all of the following SHALL be 0: line_ack, line_error, busy, bus_req_valid, bus_req_addr, line_data, counters, latched address, error flag.
REQ-018 Reset mid-refill SHALL abandon the refill with no ack or error pulse; responses arriving after reset release SHALL be ignored per REQ-015.

Configuration
REQ-019 Macro REFILL_TIMEOUT_EN:
- Defined: in FILL, a watchdog SHALL clear on entry and on each bus_resp_valid, and count otherwise. Reaching TIMEOUT_CYCLES SHALL go to FAIL (line_error pulse). Late responses are then dropped per REQ-015.
- Undefined: no watchdog; FILL waits indefinitely.

Verification
REQ-020 line_req with line_addr=0x0000_1234_5678_9A7F, ready=1, 1-cycle responses with data 0x1111*(k+1) -> bus_req_addr beats 0x...9A40..0x...9A78 step 8; line_ack at cycle 10; line_data[63:0]=0x1111, [511:448]=0x8888.
REQ-021 bus_req_ready=0 for cycles 1-5, then 1 -> first issue at cycle 6; bus_req_addr stable while stalled; exactly 8 issues; single line_ack.
REQ-022 bus_resp_error=1 on beat 3 -> all 8 beats collected; line_error one cycle; line_ack never asserted.
REQ-023 Second line_req during FILL, and bus_resp_valid in IDLE -> both ignored; busy=1 throughout FILL; line_data unchanged.
REQ-024 rst_n low at cycle 4 of a refill -> outputs 0 immediately; after release, stray responses ignored; next line_req completes normally.
REQ-025 REFILL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no responses -> line_error pulse 16 cycles after the last watchdog clear, then IDLE; undefined -> busy stays 1.

Source files
------------

// File: rtl/refill_responder.sv
// refill_responder: assembles a 64-byte cache line from eight in-order 64-bit bus beats.
// Optional response watchdog enabled by defining REFILL_TIMEOUT_EN.
module refill_responder #(
  parameter int PADDR_WIDTH    = 56,
  parameter int LINE_SIZE      = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     line_req,
  input  logic [PADDR_WIDTH-1:0]   line_addr,
  output logic                     line_ack,
  output logic [LINE_SIZE*8-1:0]   line_data,
  output logic                     line_error,
  output logic                     busy,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic [PADDR_WIDTH-1:0]   bus_req_addr,
  input  logic                     bus_resp_valid,
  input  logic [63:0]              bus_resp_data,
  input  logic                     bus_resp_error
);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2, FAIL = 2'd3;
  logic [1:0]               state_q, state_d;
  logic [PADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]               issue_q, issue_d, resp_q, resp_d;
  logic                     err_q, err_d;
  logic [LINE_SIZE*8-1:0]   data_q, data_d;
  logic                     issue;
`ifdef REFILL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif
  assign busy          = state_q != IDLE;
  assign line_ack      = state_q == DONE;
  assign line_error    = state_q == FAIL;
  assign line_data     = data_q;
  assign bus_req_valid = state_q == FILL && !issue_q[3];
  // low six bits of addr_q are always zero, so OR-ing in the beat offset is exact
  assign bus_req_addr  = addr_q | {{(PADDR_WIDTH-6){1'b0}}, issue_q[2:0], 3'b000};
  assign issue         = bus_req_valid && bus_req_ready;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    resp_d  = resp_q;
    err_d   = err_q;
    data_d  = data_q;
    if (state_q == IDLE && line_req) begin
      addr_d  = line_addr & {{(PADDR_WIDTH-6){1'b1}}, 6'b0};
      issue_d = '0;
      resp_d  = '0;
      err_d   = 1'b0;
      state_d = FILL;
    end
    if (state_q == FILL) begin
      issue_d = issue ? issue_q + 4'd1 : issue_q;
      if (bus_resp_valid) begin
        data_d[{resp_q[2:0], 6'b0} +: 64] = bus_resp_data;
        resp_d = resp_q + 4'd1;
        err_d  = err_q | bus_resp_error;
        if (resp_q == 4'd7) state_d = err_d ? FAIL : DONE;
      end
    end
    if (state_q == DONE || state_q == FAIL) state_d = IDLE;
`ifdef REFILL_TIMEOUT_EN
    // watchdog restarts on entry to FILL and on every response
    wd_d = (state_q == FILL && !bus_resp_valid) ? wd_q + WW'(1) : '0;
    if (state_q == FILL && state_d == FILL && wd_d == WW'(TIMEOUT_CYCLES)) state_d = FAIL;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      issue_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
`ifdef REFILL_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      data_q  <= data_d;
`ifdef REFILL_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end
endmodule

// File: tb/tb_refill_responder.sv
// tb_refill_responder: directed checks of refill_responder beat issue, assembly, errors and reset.
module tb_refill_responder;
  logic         clk = 1'b0, rst_n = 1'b0, line_req = 1'b0;
  logic [55:0]  line_addr = '0;
  logic         line_ack, line_error, busy, bus_req_valid;
  logic [511:0] line_data;
  logic         bus_req_ready = 1'b0, bus_resp_valid = 1'b0, bus_resp_error = 1'b0;
  logic [55:0]  bus_req_addr;
  logic [63:0]  bus_resp_data = '0;
  int n_cmp = 0, n_bad = 0;
  int issues, first_issue, ack_cnt, ack_cyc, err_cnt, err_cyc, addr_bad, busy_low, both;

  refill_responder #(.PADDR_WIDTH(56), .LINE_SIZE(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_addr(line_addr),
    .line_ack(line_ack), .line_data(line_data), .line_error(line_error), .busy(busy),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_resp_error(bus_resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // cycle 0 raises line_req; the bench then acts as a 1-cycle-latency responder
  task automatic refill(input logic [55:0] a, input int stall, input int eb, input bit noresp, input bit req_again);
    logic [55:0] base;
    bit pend, done;
    int r;
    base = a & ~56'h3f;
    pend = 0; done = 0; r = 0;
    issues = 0; first_issue = -1; ack_cnt = 0; ack_cyc = -1; err_cnt = 0; err_cyc = -1;
    addr_bad = 0; busy_low = 0; both = 0;
    line_addr = a;
    line_req = 1'b1;
    tick;
    line_req = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      bus_req_ready  = cyc > stall;
      bus_resp_valid = pend && !noresp;
      bus_resp_data  = pend ? 64'h1111 * 64'(r + 1) : 64'hbad0;
      bus_resp_error = pend && (r == eb);
      line_req  = req_again && cyc == 3;
      line_addr = (req_again && cyc == 3) ? 56'hff_ffff_ffff_ff00 : a;
      #1;
      if (bus_resp_valid) r++;
      if (bus_req_valid && bus_req_addr != base + 56'(8 * issues)) addr_bad++;
      pend = bus_req_valid && bus_req_ready;
      if (pend) begin
        if (first_issue < 0) first_issue = cyc;
        issues++;
      end
      if (!busy && !done) busy_low++;
      if (line_ack && line_error) both++;
      if (line_ack) begin ack_cnt++; ack_cyc = cyc; done = 1; end
      if (line_error) begin err_cnt++; err_cyc = cyc; done = 1; end
      tick;
    end
    line_req = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_error = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", bus_req_valid, 0);
    check("rst_addr", bus_req_addr, 0);
    check("rst_data", line_data[63:0] | line_data[511:448], 0);
    check("rst_ack_err", {line_ack, line_error}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    refill(56'h00_1234_5678_9A7F, 0, -1, 0, 0);
    check("basic_issues", issues, 8);
    check("basic_first_issue", first_issue, 1);
    check("basic_addr", addr_bad, 0);
    check("basic_ack_cyc", ack_cyc, 10);
    check("basic_ack_cnt", ack_cnt, 1);
    check("basic_err_cnt", err_cnt, 0);
    check("basic_busy", busy_low, 0);
    check("basic_beat0", line_data[63:0], 64'h1111);
    check("basic_beat3", line_data[255:192], 64'h4444);
    check("basic_beat7", line_data[511:448], 64'h8888);

    refill(56'h00_0000_0000_1000, 5, -1, 0, 0);
    check("stall_first_issue", first_issue, 6);
    check("stall_addr", addr_bad, 0);
    check("stall_issues", issues, 8);
    check("stall_ack_cnt", ack_cnt, 1);
    check("stall_ack_cyc", ack_cyc, 15);

    refill(56'h00_0000_0000_2040, 0, 3, 0, 0);
    check("err_err_cnt", err_cnt, 1);
    check("err_err_cyc", err_cyc, 10);
    check("err_ack_cnt", ack_cnt, 0);
    check("err_both", both, 0);
    check("err_beat3", line_data[255:192], 64'h4444);
    check("err_beat7", line_data[511:448], 64'h8888);

    refill(56'h00_0000_0000_3000, 0, -1, 0, 1);
    check("reqagain_addr", addr_bad, 0);
    check("reqagain_issues", issues, 8);
    check("reqagain_ack_cyc", ack_cyc, 10);
    check("reqagain_busy", busy_low, 0);
    bus_resp_valid = 1'b1; bus_resp_data = 64'hdead_beef_dead_beef;
    repeat (3) begin
      tick;
      check("idle_resp_busy", {busy, line_ack, line_error}, 0);
    end
    bus_resp_valid = 1'b0;
    check("idle_resp_data", line_data[63:0], 64'h1111);

    line_addr = 56'h00_0000_0000_4000;
    line_req = 1'b1; bus_req_ready = 1'b1;
    tick;
    line_req = 1'b0;
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus_req_valid, 0);
    check("mid_rst_addr", bus_req_addr, 0);
    check("mid_rst_data", line_data[63:0], 0);
    @(negedge clk) rst_n = 1'b1;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_data = 64'h5555;
    repeat (3) begin
      tick;
      check("stray_resp", {busy, line_ack, line_error}, 0);
    end
    bus_resp_valid = 1'b0;
    refill(56'h00_0000_0000_5000, 0, -1, 0, 0);
    check("post_rst_ack_cyc", ack_cyc, 10);
    check("post_rst_beat0", line_data[63:0], 64'h1111);

    refill(56'h00_0000_0000_6000, 0, -1, 1, 0);
    check("noresp_issues", issues, 8);
    check("noresp_ack_cnt", ack_cnt, 0);
`ifdef REFILL_TIMEOUT_EN
    check("noresp_err_cnt", err_cnt, 1);
    check("noresp_err_cyc", err_cyc, 17);
    check("noresp_idle", busy, 0);
`else
    check("noresp_err_cnt", err_cnt, 0);
    check("noresp_busy_low", busy_low, 0);
    check("noresp_busy", busy, 1);
`endif
    rst_n = 1'b0;
    #1;
    check("final_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
